// File: rtl/gshare_predictor_pkg.sv
// rtl/gshare_predictor_pkg.sv - shared constants and helpers for the gshare predictor
// Contents:
//   GHR_BITS_DEFAULT  default global history width
//   PHT_SNT..PHT_ST   2-bit saturating counter encodings
//   pht_next()        saturating counter update
package gshare_predictor_pkg;

  localparam int GHR_BITS_DEFAULT = 5;

  localparam logic [1:0] PHT_SNT = 2'b00;
  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_WT  = 2'b10;
  localparam logic [1:0] PHT_ST  = 2'b11;

  // Counter moves one step toward the outcome and holds at either end.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != PHT_ST) begin
      nxt = cnt + 2'd1;
    end else if (!taken && cnt != PHT_SNT) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_btb.sv
// rtl/gshare_btb.sv - branch target buffer: valid/tag/target/jump arrays
// Ports:
//   clk, reset          pipeline clock, synchronous active-high reset (clears valid bits)
//   rd_idx, rd_tag      combinational lookup address and tag
//   rd_hit              entry valid and tag matches
//   rd_target, rd_jump  stored target and jump flag of the indexed entry
//   wr_en               write one entry at the clock edge
//   wr_idx, wr_tag, wr_target, wr_jump  entry contents to write
module gshare_btb #(
  parameter int IDX_BITS = 5,
  parameter int ENTRIES  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX_BITS-1:0]    rd_idx,
  input  logic [29-IDX_BITS:0]   rd_tag,
  output logic                   rd_hit,
  output logic [31:0]            rd_target,
  output logic                   rd_jump,
  input  logic                   wr_en,
  input  logic [IDX_BITS-1:0]    wr_idx,
  input  logic [29-IDX_BITS:0]   wr_tag,
  input  logic [31:0]            wr_target,
  input  logic                   wr_jump
);

  logic                  valid_q  [ENTRIES];
  logic [29-IDX_BITS:0]  tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic                  jump_q   [ENTRIES];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];
  assign rd_jump   = jump_q[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only ever read through a valid entry.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      jump_q[wr_idx]   <= wr_jump;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with BTB for the IF stage
// Ports:
//   clk, reset      pipeline clock, synchronous active-high reset
//   IF_PC           fetch PC
//   pred_next_pc    predicted next fetch PC (combinational)
//   pred_ghr        history used for this lookup, carried down the pipe to EX
//   upd_valid       one resolved control instruction in EX this cycle
//   upd_pc, upd_ghr PC and carried history of the resolved instruction
//   upd_is_branch   conditional branch
//   upd_is_jump     JAL/JALR
//   upd_taken       actual outcome
//   upd_target      actual target
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int GHR_BITS = GHR_BITS_DEFAULT,
  parameter int ENTRIES  = 1 << GHR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         IF_PC,
  output logic [31:0]         pred_next_pc,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_is_branch,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target
);

  localparam int TAG_W = 30 - GHR_BITS;

  logic [GHR_BITS-1:0] ghr;
  logic [1:0]          pht [ENTRIES];

  logic [GHR_BITS-1:0] lk_btb_idx;
  logic [GHR_BITS-1:0] lk_pht_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                btb_hit;
  logic [31:0]         btb_target;
  logic                btb_jump;
  logic                pred_taken;
  logic [31:0]         pc_plus4;

  logic [GHR_BITS-1:0] up_btb_idx;
  logic [GHR_BITS-1:0] up_pht_idx;
  logic [TAG_W-1:0]    up_tag;
  logic                btb_we;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[1:0]};

  // Lookup: BTB uses PC bits only, PHT folds in the global history.
  assign lk_btb_idx = IF_PC[GHR_BITS+1:2];
  assign lk_pht_idx = lk_btb_idx ^ ghr;
  assign lk_tag     = IF_PC[31:GHR_BITS+2];
  assign pc_plus4   = IF_PC + 32'd4;

  assign pred_taken   = !reset && btb_hit && (btb_jump || pht[lk_pht_idx][1]);
  assign pred_next_pc = pred_taken ? btb_target : pc_plus4;
  assign pred_ghr     = reset ? '0 : ghr;

  // Update side.
  assign up_btb_idx = upd_pc[GHR_BITS+1:2];
  assign up_pht_idx = up_btb_idx ^ upd_ghr;
  assign up_tag     = upd_pc[31:GHR_BITS+2];
  assign btb_we     = upd_valid && upd_taken && (upd_is_branch || upd_is_jump);

  gshare_btb #(
    .IDX_BITS (GHR_BITS),
    .ENTRIES  (ENTRIES)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (lk_btb_idx),
    .rd_tag    (lk_tag),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .rd_jump   (btb_jump),
    .wr_en     (btb_we),
    .wr_idx    (up_btb_idx),
    .wr_tag    (up_tag),
    .wr_target (upd_target),
    .wr_jump   (upd_is_jump)
  );

  // History is only advanced by resolved conditional branches, never at fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= PHT_WNT;
      end
    end else if (upd_valid && upd_is_branch) begin
      pht[up_pht_idx] <= pht_next(pht[up_pht_idx], upd_taken);
      ghr             <= {ghr[GHR_BITS-2:0], upd_taken};
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed self-checking bench for gshare_predictor
module tb_gshare_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] IF_PC;
  logic [31:0] pred_next_pc;
  logic [4:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [4:0]  upd_ghr;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;

  int errors = 0;
  int checks = 0;

  gshare_predictor #(.GHR_BITS(5), .ENTRIES(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .IF_PC         (IF_PC),
    .pred_next_pc  (pred_next_pc),
    .pred_ghr      (pred_ghr),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_ghr       (upd_ghr),
    .upd_is_branch (upd_is_branch),
    .upd_is_jump   (upd_is_jump),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [4:0] g, input logic br,
                         input logic jmp, input logic tk, input logic [31:0] tgt);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_ghr       = g;
    upd_is_branch = br;
    upd_is_jump   = jmp;
    upd_taken     = tk;
    upd_target    = tgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [4:0] g, input logic br,
                     input logic jmp, input logic tk, input logic [31:0] tgt);
    set_upd(pc, g, br, jmp, tk, tgt);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    IF_PC = pc;
    #1;
    check(tag, pred_next_pc, exp);
  endtask

  task automatic look_ghr(input string tag, input logic [4:0] exp);
    #1;
    check(tag, {27'd0, pred_ghr}, {27'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    IF_PC = 32'h0;
    upd_valid = 1'b0;
    upd_pc = 32'h0;
    upd_ghr = 5'd0;
    upd_is_branch = 1'b0;
    upd_is_jump = 1'b0;
    upd_taken = 1'b0;
    upd_target = 32'h0;

    // Reset, with an update presented during reset that must be dropped.
    tick();
    set_upd(32'h60, 5'd0, 1'b0, 1'b1, 1'b1, 32'h200);
    look("rst_hold_pc", 32'h100, 32'h104);
    look_ghr("rst_hold_ghr", 5'd0);
    tick();
    upd_valid = 1'b0;
    reset = 1'b0;

    look("after_rst_pc", 32'h100, 32'h104);
    look_ghr("after_rst_ghr", 5'd0);
    look("wrap_pc", 32'hFFFF_FFFC, 32'h0000_0000);
    look("rst_upd_dropped", 32'h60, 32'h64);

    // JAL learn; same-cycle lookup still sees the empty entry.
    set_upd(32'h20, 5'd0, 1'b0, 1'b1, 1'b1, 32'h80);
    look("jal_same_cycle", 32'h20, 32'h24);
    tick();
    upd_valid = 1'b0;
    look("jal_learned", 32'h20, 32'h80);
    look_ghr("jal_ghr", 5'd0);

    // Branch 0x40 -> 0x10 taken twice: GHR 0->1->3.
    upd(32'h40, 5'd0, 1'b1, 1'b0, 1'b1, 32'h10);
    look_ghr("br1_ghr", 5'd1);
    look("br1_pht11_wnt", 32'h40, 32'h44);
    upd(32'h40, 5'd1, 1'b1, 1'b0, 1'b1, 32'h10);
    look_ghr("br2_ghr", 5'd3);
    look("br2_pht13_wnt", 32'h40, 32'h44);

    // Five not-taken branches at 0x400 shift GHR back to 0 (PHT[0x1F] only).
    for (int i = 0; i < 5; i++) begin
      upd(32'h400, 5'h1F, 1'b1, 1'b0, 1'b0, 32'h900);
    end
    look_ghr("shift0_ghr", 5'd0);
    look("nt_no_btb", 32'h400, 32'h404);
    look("pht10_wt", 32'h40, 32'h10);
    upd(32'h400, 5'h1E, 1'b1, 1'b0, 1'b1, 32'h900);
    look_ghr("shift1_ghr", 5'd1);
    look("pht11_wt", 32'h40, 32'h10);

    // Saturation at PHT[0x1D^0x1E = 0x03]: 4 taken then 1 not-taken.
    for (int i = 0; i < 4; i++) begin
      upd(32'h74, 5'h1E, 1'b1, 1'b0, 1'b1, 32'h1234_5670);
    end
    look_ghr("sat_ghr", 5'h1F);
    upd(32'h74, 5'h1E, 1'b1, 1'b0, 1'b0, 32'h1234_5670);
    look_ghr("sat_nt_ghr", 5'h1E);
    look("sat_still_taken", 32'h74, 32'h1234_5670);

    // Same-cycle overwrite: old target now, new target next cycle.
    set_upd(32'h20, 5'd0, 1'b0, 1'b1, 1'b1, 32'h300);
    look("same_cycle_old", 32'h20, 32'h80);
    tick();
    upd_valid = 1'b0;
    look("same_cycle_new", 32'h20, 32'h300);
    look("hold_repeat", 32'h20, 32'h300);

    // Aliasing tag: 0x40 and 0xC0 share BTB index 0x10.
    upd(32'h40, 5'd0, 1'b0, 1'b1, 1'b1, 32'h10);
    look("alias_owner", 32'h40, 32'h10);
    look("alias_miss", 32'hC0, 32'hC4);

    // Non-control update has no effect.
    upd(32'h100, 5'd0, 1'b0, 1'b0, 1'b1, 32'h700);
    look("nonctl_btb", 32'h100, 32'h104);
    look_ghr("nonctl_ghr", 5'h1E);

    // Not-taken branch leaves BTB alone but shifts GHR.
    upd(32'h20, 5'd0, 1'b1, 1'b0, 1'b0, 32'h500);
    look("nt_keeps_btb", 32'h20, 32'h300);
    look_ghr("nt_ghr", 5'h1C);

    // Mid-sequence reset wipes everything.
    reset = 1'b1;
    set_upd(32'h60, 5'd0, 1'b0, 1'b1, 1'b1, 32'h200);
    look("mid_rst_pc", 32'h20, 32'h24);
    look_ghr("mid_rst_ghr", 5'd0);
    tick();
    upd_valid = 1'b0;
    reset = 1'b0;
    look("mid_rst_jal_gone", 32'h20, 32'h24);
    look("mid_rst_br_gone", 32'h74, 32'h78);
    look("mid_rst_upd_dropped", 32'h60, 32'h64);
    look_ghr("mid_rst_ghr_after", 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
